// File: rtl/txhex_pkg.sv
// Shared definitions for the hex text streamer: FSM encoding, ASCII
// constants and the nibble-to-character conversion.
package txhex_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PFX0,
    S_PFX1,
    S_SKIP,
    S_DIGIT,
    S_CR,
    S_LF
  } txhex_state_t;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_X    = 8'h78;
  localparam logic [7:0] ASCII_CR   = 8'h0d;
  localparam logic [7:0] ASCII_LF   = 8'h0a;

  // Lowercase hex digit for a nibble
  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    if (nib < 4'd10)
      return ASCII_ZERO + {4'h0, nib};
    else
      return 8'h57 + {4'h0, nib};
  endfunction

endpackage

// File: rtl/txhex_fifo.sv
// Small synchronous word FIFO with registered full/empty flags and a
// fall-through read port so the consumer sees the head word directly.
module txhex_fifo #(
  parameter int DW     = 32,
  parameter int LGFIFO = 2
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] rd_data,
  output logic          full,
  output logic          empty
);

  localparam int DEPTH = 2 ** LGFIFO;
  localparam logic [LGFIFO:0] DEPTH_CNT = (LGFIFO + 1)'(DEPTH);

  logic [DW-1:0]     mem [DEPTH];
  logic [LGFIFO-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [LGFIFO:0]   count_reg, count_next;
  logic              full_reg, empty_reg;
  logic              push_ok, pop_ok;

  // A push while full is refused even if a pop frees a slot this cycle
  assign push_ok = push && !full_reg;
  assign pop_ok  = pop && !empty_reg;

  always_comb begin
    count_next = count_reg;
    case ({push_ok, pop_ok})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (push_ok)
      mem[wr_ptr_reg] <= push_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      full_reg   <= 1'b0;
      empty_reg  <= 1'b1;
    end else begin
      if (push_ok)
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok)
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_next;
      full_reg  <= (count_next == DEPTH_CNT);
      empty_reg <= (count_next == '0);
    end
  end

  assign rd_data = mem[rd_ptr_reg];
  assign full    = full_reg;
  assign empty   = empty_reg;

endmodule

// File: rtl/txhex_stream.sv
// Buffers words and prints each as ASCII hex ("0x", digits, CR/LF) over a
// byte handshake toward a UART transmitter.
module txhex_stream
  import txhex_pkg::*;
#(
  parameter int DW        = 32,
  parameter int LGFIFO    = 2,
  parameter int PREFIX    = 1,
  parameter int EOL       = 2,
  parameter int ZSUPPRESS = 0
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_stb,
  input  logic [DW-1:0] i_data,
  output logic          o_full,
  output logic          o_idle,
  output logic          o_tx_stb,
  output logic [7:0]    o_tx_data,
  input  logic          i_tx_busy
);

  localparam int CW = $clog2(DW / 4 + 1);
  localparam logic [CW-1:0] NDIG = CW'(DW / 4);
  localparam txhex_state_t AFTER_PFX = (ZSUPPRESS != 0) ? S_SKIP : S_DIGIT;
  localparam txhex_state_t FIRST_ST  = (PREFIX != 0) ? S_PFX0 : AFTER_PFX;
  localparam txhex_state_t EOL_ST    = (EOL == 2) ? S_CR : ((EOL == 1) ? S_LF : S_IDLE);

  txhex_state_t  state_reg, state_next;
  logic [DW-1:0] shift_reg, shift_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          stb_reg, stb_next;
  logic [7:0]    data_reg, data_next;
  logic          fifo_pop, fifo_empty, fifo_full;
  logic [DW-1:0] fifo_data;
  logic [3:0]    top_nib;
  logic [7:0]    byte_val;
  logic          is_byte_state;
  logic          take;

  txhex_fifo #(
    .DW     (DW),
    .LGFIFO (LGFIFO)
  ) u_fifo (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .push      (i_stb),
    .push_data (i_data),
    .pop       (fifo_pop),
    .rd_data   (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign top_nib = shift_reg[DW-1 -: 4];
  assign take    = stb_reg && !i_tx_busy;

  always_comb begin
    byte_val      = 8'h00;
    is_byte_state = 1'b1;
    case (state_reg)
      S_PFX0:  byte_val = ASCII_ZERO;
      S_PFX1:  byte_val = ASCII_X;
      S_DIGIT: byte_val = hex_ascii(top_nib);
      S_CR:    byte_val = ASCII_CR;
      S_LF:    byte_val = ASCII_LF;
      default: is_byte_state = 1'b0;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    shift_next = shift_reg;
    cnt_next   = cnt_reg;
    stb_next   = stb_reg;
    data_next  = data_reg;
    fifo_pop   = 1'b0;

    if (state_reg == S_IDLE) begin
      if (!fifo_empty) begin
        fifo_pop   = 1'b1;
        shift_next = fifo_data;
        cnt_next   = NDIG;
        state_next = FIRST_ST;
      end
    end else if (state_reg == S_SKIP) begin
      if (top_nib == 4'h0 && cnt_reg > CW'(1)) begin
        shift_next = shift_reg << 4;
        cnt_next   = cnt_reg - CW'(1);
      end else begin
        state_next = S_DIGIT;
      end
    end else if (is_byte_state) begin
      // Present the byte one cycle after entering the state, hold until taken
      if (!stb_reg) begin
        stb_next  = 1'b1;
        data_next = byte_val;
      end else if (take) begin
        stb_next = 1'b0;
        case (state_reg)
          S_PFX0:  state_next = S_PFX1;
          S_PFX1:  state_next = AFTER_PFX;
          S_DIGIT: begin
            shift_next = shift_reg << 4;
            cnt_next   = cnt_reg - CW'(1);
            state_next = (cnt_reg == CW'(1)) ? EOL_ST : S_DIGIT;
          end
          S_CR:    state_next = S_LF;
          default: state_next = S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_reg <= S_IDLE;
      shift_reg <= '0;
      cnt_reg   <= '0;
      stb_reg   <= 1'b0;
      data_reg  <= 8'h00;
    end else begin
      state_reg <= state_next;
      shift_reg <= shift_next;
      cnt_reg   <= cnt_next;
      stb_reg   <= stb_next;
      data_reg  <= data_next;
    end
  end

  assign o_tx_stb  = stb_reg;
  assign o_tx_data = data_reg;
  assign o_full    = fifo_full;
  assign o_idle    = fifo_empty && (state_reg == S_IDLE);

endmodule

// File: tb/tb_txhex_stream.sv
// Scoreboard bench: three streamer configurations, expected text queued at
// push time and compared byte by byte as the transmitter takes each byte.
module tb_txhex_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic        stb_in  [3];
  logic [31:0] data_in [3];
  logic        full    [3];
  logic        idle    [3];
  logic        tx_stb  [3];
  logic [7:0]  tx_data [3];
  logic        busy    [3];
  logic        busy_a;
  int          busy_mode;
  int          cyc;

  logic [7:0]  q [3][$];
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  assign busy[0] = busy_a;
  assign busy[1] = 1'b0;
  assign busy[2] = 1'b0;

  txhex_stream #(.DW(32), .LGFIFO(2), .PREFIX(1), .EOL(2), .ZSUPPRESS(0)) u_a (
    .i_clk(clk), .i_reset(rst), .i_stb(stb_in[0]), .i_data(data_in[0]),
    .o_full(full[0]), .o_idle(idle[0]), .o_tx_stb(tx_stb[0]),
    .o_tx_data(tx_data[0]), .i_tx_busy(busy[0]));

  txhex_stream #(.DW(32), .LGFIFO(2), .PREFIX(1), .EOL(2), .ZSUPPRESS(1)) u_b (
    .i_clk(clk), .i_reset(rst), .i_stb(stb_in[1]), .i_data(data_in[1]),
    .o_full(full[1]), .o_idle(idle[1]), .o_tx_stb(tx_stb[1]),
    .o_tx_data(tx_data[1]), .i_tx_busy(busy[1]));

  txhex_stream #(.DW(12), .LGFIFO(2), .PREFIX(0), .EOL(0), .ZSUPPRESS(0)) u_c (
    .i_clk(clk), .i_reset(rst), .i_stb(stb_in[2]), .i_data(data_in[2][11:0]),
    .o_full(full[2]), .o_idle(idle[2]), .o_tx_stb(tx_stb[2]),
    .o_tx_data(tx_data[2]), .i_tx_busy(busy[2]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic expect_str(input int g, input string s);
    for (int i = 0; i < s.len(); i++)
      q[g].push_back(s[i]);
  endtask

  task automatic push(input int g, input logic [31:0] d);
    stb_in[g]  = 1'b1;
    data_in[g] = d;
    @(posedge clk); #1;
    stb_in[g]  = 1'b0;
  endtask

  task automatic drain(input int g, input int budget);
    int n = 0;
    while (q[g].size() != 0 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    if (q[g].size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain%0d: %0d bytes still outstanding after %0d cycles", g, q[g].size(), budget);
      q[g].delete();
    end
    chk($sformatf("idle_after_drain%0d", g), 32'(idle[g]), 32'd1);
  endtask

  task automatic wait_stb(input int g, input int budget);
    int n = 0;
    while (!tx_stb[g] && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk($sformatf("stb_seen%0d", g), 32'(tx_stb[g]), 32'd1);
  endtask

  // Transmitter busy model for instance 0: 0 ready, 1 one free cycle in 11, 2 held busy
  initial begin
    busy_a = 1'b0;
    cyc    = 0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      case (busy_mode)
        0:       busy_a = 1'b0;
        1:       busy_a = ((cyc % 11) != 0);
        default: busy_a = 1'b1;
      endcase
    end
  end

  for (genvar gi = 0; gi < 3; gi++) begin : g_mon
    logic       hold = 1'b0;
    logic [7:0] hold_data = 8'h00;
    logic [7:0] exp_b;
    always @(negedge clk) begin
      if (hold && !rst) begin
        chk($sformatf("hold_stb%0d", gi), 32'(tx_stb[gi]), 32'd1);
        chk($sformatf("hold_data%0d", gi), 32'(tx_data[gi]), 32'(hold_data));
      end
      if (tx_stb[gi] && !busy[gi]) begin
        if (q[gi].size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL byte%0d: got unexpected %h, expected no byte", gi, tx_data[gi]);
        end else begin
          exp_b = q[gi].pop_front();
          chk($sformatf("byte%0d", gi), 32'(tx_data[gi]), 32'(exp_b));
        end
      end
      hold      = tx_stb[gi] && busy[gi] && !rst;
      hold_data = tx_data[gi];
    end
  end

  initial begin
    busy_mode = 0;
    rst = 1'b1;
    for (int g = 0; g < 3; g++) begin
      stb_in[g]  = 1'b0;
      data_in[g] = 32'h0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("reset_stb",   32'(tx_stb[0]),  32'd0);
    chk("reset_data",  32'(tx_data[0]), 32'd0);
    chk("reset_full",  32'(full[0]),    32'd0);
    chk("reset_idle",  32'(idle[0]),    32'd1);
    rst = 1'b0;
    @(posedge clk); #1;

    // Full 32-bit message and first-byte latency
    expect_str(0, "0x12ab00ff\r\n");
    push(0, 32'h12AB00FF);
    chk("lat_stb_n",  32'(tx_stb[0]), 32'd0);
    @(posedge clk); #1;
    chk("lat_stb_n1", 32'(tx_stb[0]), 32'd0);
    @(posedge clk); #1;
    chk("lat_stb_n2", 32'(tx_stb[0]), 32'd1);
    chk("lat_data",   32'(tx_data[0]), 32'h30);
    drain(0, 200);

    // Zero suppression, fixed width without prefix or terminator
    expect_str(1, "0xa\r\n");
    expect_str(1, "0x0\r\n");
    push(1, 32'h0000000A);
    push(1, 32'h00000000);
    expect_str(2, "f0e");
    push(2, 32'h00000F0E);
    drain(1, 200);
    drain(2, 200);

    // FIFO fills while the FSM is stalled on a busy transmitter
    busy_mode = 2;
    expect_str(0, "0x11111111\r\n");
    push(0, 32'h11111111);
    wait_stb(0, 20);
    expect_str(0, "0x00000001\r\n");
    push(0, 32'h00000001);
    expect_str(0, "0x22222222\r\n");
    push(0, 32'h22222222);
    expect_str(0, "0x3c3c3c3c\r\n");
    push(0, 32'h3C3C3C3C);
    chk("full_after3", 32'(full[0]), 32'd0);
    expect_str(0, "0x89abcdef\r\n");
    push(0, 32'h89ABCDEF);
    chk("full_after4", 32'(full[0]), 32'd1);
    push(0, 32'h55555555);
    chk("full_after5", 32'(full[0]), 32'd1);
    busy_mode = 1;
    drain(0, 3000);

    // Long stall with a byte on offer
    busy_mode = 2;
    expect_str(0, "0x0badf00d\r\n");
    push(0, 32'h0BADF00D);
    wait_stb(0, 20);
    repeat (50) @(posedge clk);
    #1;
    chk("stall_data", 32'(tx_data[0]), 32'h30);
    busy_mode = 0;
    drain(0, 300);

    // Reset while the third digit is on offer
    expect_str(0, "0xdea");
    push(0, 32'hDEADBEEF);
    for (int n = 0; n < 100; n++) begin
      if (tx_stb[0] && tx_data[0] == 8'h61) break;
      @(posedge clk); #1;
    end
    chk("rst_mid_seen", 32'(tx_data[0]), 32'h61);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_mid_stb",  32'(tx_stb[0]), 32'd0);
    chk("rst_mid_idle", 32'(idle[0]),   32'd1);
    chk("rst_mid_q",    32'(q[0].size()), 32'd0);
    expect_str(0, "0x0000cafe\r\n");
    push(0, 32'h0000CAFE);
    drain(0, 300);

    repeat (5) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
